// File: rtl/gray_pixel_packer.sv
// Rounds fixed-point gray samples to 8-bit pixels, packs four per 32-bit word
// and buffers the words in a small FIFO behind a valid/ready output.
module gray_pixel_packer #(
    parameter int unsigned FRAC_BITS = 8,
    parameter int unsigned DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_gray,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [3:0]  out_keep,
    output logic        out_last,
    output logic        overflow,
    input  logic        clr_overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [32:0] HALF = 33'd1 << (FRAC_BITS - 1);

    logic [32:0] sum;
    logic [32:0] shifted;
    logic [7:0]  pix;

    logic [1:0]  idx_q;
    logic [31:0] asm_q;
    logic [31:0] asm_next;
    logic [2:0]  fill;
    logic [3:0]  commit_keep;
    logic        commit;

    logic [31:0] mem_data [DEPTH];
    logic [3:0]  mem_keep [DEPTH];
    logic        mem_last [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic        full;
    logic        pop;
    logic        push;
    logic        drop;

    // 33-bit sum so a near-full-scale input cannot wrap before saturation
    always_comb begin
        sum     = {1'b0, in_gray} + HALF;
        shifted = sum >> FRAC_BITS;
        pix     = (|shifted[32:8]) ? 8'hFF : shifted[7:0];
    end

    always_comb begin
        asm_next = asm_q;
        if (in_valid) begin
            asm_next[{idx_q, 3'b000} +: 8] = pix;
        end
        fill   = {1'b0, idx_q} + {2'b00, in_valid};
        commit = (in_valid && (idx_q == 2'd3)) || (flush && (fill != 3'd0));
        case (fill)
            3'd1:    commit_keep = 4'b0001;
            3'd2:    commit_keep = 4'b0011;
            3'd3:    commit_keep = 4'b0111;
            3'd4:    commit_keep = 4'b1111;
            default: commit_keep = 4'b0000;
        endcase
    end

    // Assembly register is zeroed on every commit so unfilled bytes of a partial word read 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q <= '0;
            asm_q <= '0;
        end else if (commit) begin
            idx_q <= '0;
            asm_q <= '0;
        end else if (in_valid) begin
            idx_q <= idx_q + 2'd1;
            asm_q <= asm_next;
        end
    end

    always_comb begin
        out_valid = (count != '0);
        full      = (count == FULL_CNT);
        pop       = out_valid && out_ready;
        push      = commit && (!full || pop);
        drop      = commit && full && !pop;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= asm_next;
            mem_keep[wr_ptr] <= commit_keep;
            mem_last[wr_ptr] <= flush;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

    // Head fields are gated so the storage array itself needs no reset
    always_comb begin
        out_data = '0;
        out_keep = '0;
        out_last = 1'b0;
        if (out_valid) begin
            out_data = mem_data[rd_ptr];
            out_keep = mem_keep[rd_ptr];
            out_last = mem_last[rd_ptr];
        end
    end

endmodule

// File: tb/tb_gray_pixel_packer.sv
// Directed bench for gray_pixel_packer: vector table for single-word cases,
// hand-written sequences for backpressure, overflow and reset.
module tb_gray_pixel_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_gray;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
    logic        overflow;
    logic        clr_overflow;

    int errors = 0;
    int checks = 0;

    gray_pixel_packer #(.FRAC_BITS(8), .DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_gray      (in_gray),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_keep     (out_keep),
        .out_last     (out_last),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] g;
        logic        f;
        logic        rdy;
        logic        clr;
        logic        ev;
        logic [31:0] ed;
        logic [3:0]  ek;
        logic        el;
        logic        eo;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic [31:0] g, logic f, logic rdy,
                                logic ev, logic [31:0] ed, logic [3:0] ek, logic el);
        vec_t r;
        r.v = v; r.g = g; r.f = f; r.rdy = rdy; r.clr = 1'b0;
        r.ev = ev; r.ed = ed; r.ek = ek; r.el = el; r.eo = 1'b0;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic [31:0] ed,
                           input logic [3:0] ek, input logic el, input logic eo);
        chk({tag, ".valid"}, 32'(out_valid), 32'(ev));
        chk({tag, ".data"},  out_data,       ed);
        chk({tag, ".keep"},  32'(out_keep),  32'(ek));
        chk({tag, ".last"},  32'(out_last),  32'(el));
        chk({tag, ".ovf"},   32'(overflow),  32'(eo));
    endtask

    task automatic pixel(input logic [7:0] p);
        in_valid = 1'b1;
        in_gray  = {16'h0, p, 8'h00};
        tick();
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] word_of(input int base);
        return {8'(base + 3), 8'(base + 2), 8'(base + 1), 8'(base)};
    endfunction

    initial begin
        // rounding, saturation, partial flush, flush+pixel, stall hold
        tbl.push_back(mk(1, 32'h0000_4C80, 0, 1, 0, 32'h0, 4'h0, 0));
        tbl.push_back(mk(1, 32'h0000_4C7F, 0, 1, 0, 32'h0, 4'h0, 0));
        tbl.push_back(mk(1, 32'h0001_2000, 0, 1, 0, 32'h0, 4'h0, 0));
        tbl.push_back(mk(1, 32'h0000_0000, 0, 1, 1, 32'h00FF_4C4D, 4'hF, 0));
        tbl.push_back(mk(0, 32'h0,         0, 1, 0, 32'h0, 4'h0, 0));
        tbl.push_back(mk(1, 32'h0000_1000, 0, 1, 0, 32'h0, 4'h0, 0));
        tbl.push_back(mk(1, 32'h0000_2000, 0, 1, 0, 32'h0, 4'h0, 0));
        tbl.push_back(mk(0, 32'h0,         1, 1, 1, 32'h0000_2010, 4'h3, 1));
        tbl.push_back(mk(0, 32'h0,         1, 1, 0, 32'h0, 4'h0, 0));
        tbl.push_back(mk(0, 32'h0,         0, 1, 0, 32'h0, 4'h0, 0));
        tbl.push_back(mk(1, 32'h0000_0100, 0, 1, 0, 32'h0, 4'h0, 0));
        tbl.push_back(mk(1, 32'h0000_0200, 0, 1, 0, 32'h0, 4'h0, 0));
        tbl.push_back(mk(1, 32'h0000_0300, 0, 1, 0, 32'h0, 4'h0, 0));
        tbl.push_back(mk(1, 32'h0000_0400, 1, 1, 1, 32'h0403_0201, 4'hF, 1));
        tbl.push_back(mk(0, 32'h0,         0, 1, 0, 32'h0, 4'h0, 0));
        tbl.push_back(mk(1, 32'h0000_0500, 0, 1, 0, 32'h0, 4'h0, 0));
        tbl.push_back(mk(1, 32'h0000_0600, 1, 1, 1, 32'h0000_0605, 4'h3, 1));
        tbl.push_back(mk(1, 32'hFFFF_FFFF, 0, 1, 0, 32'h0, 4'h0, 0));
        tbl.push_back(mk(1, 32'h0000_FF7F, 0, 1, 0, 32'h0, 4'h0, 0));
        tbl.push_back(mk(1, 32'h0000_017F, 0, 1, 0, 32'h0, 4'h0, 0));
        tbl.push_back(mk(1, 32'h0000_0180, 0, 1, 1, 32'h0201_FFFF, 4'hF, 0));
        tbl.push_back(mk(0, 32'h0,         0, 1, 0, 32'h0, 4'h0, 0));
        tbl.push_back(mk(1, 32'h0000_7FFF, 1, 1, 1, 32'h0000_0080, 4'h1, 1));
        tbl.push_back(mk(0, 32'h0,         0, 1, 0, 32'h0, 4'h0, 0));
        tbl.push_back(mk(1, 32'h0000_0300, 1, 0, 1, 32'h0000_0003, 4'h1, 1));
        tbl.push_back(mk(0, 32'h0,         0, 0, 1, 32'h0000_0003, 4'h1, 1));
        tbl.push_back(mk(0, 32'h0,         0, 1, 0, 32'h0, 4'h0, 0));

        rst = 1'b0; in_valid = 1'b0; in_gray = '0; flush = 1'b0;
        out_ready = 1'b0; clr_overflow = 1'b0;
        #12;
        chk_out("reset", 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();

        foreach (tbl[i]) begin
            in_valid     = tbl[i].v;
            in_gray      = tbl[i].g;
            flush        = tbl[i].f;
            out_ready    = tbl[i].rdy;
            clr_overflow = tbl[i].clr;
            tick();
            chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].ek, tbl[i].el, tbl[i].eo);
        end
        in_valid = 1'b0; flush = 1'b0; clr_overflow = 1'b0;

        // overflow: 20 pixels with no drain, clear asserted alongside the drop
        out_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            clr_overflow = (k == 19);
            pixel(8'(k + 1));
            if (k == 15) begin
                chk("ovf.before_drop", 32'(overflow), 32'h0);
                chk("ovf.head_while_full", out_data, word_of(1));
            end
        end
        clr_overflow = 1'b0;
        chk("ovf.set_wins", 32'(overflow), 32'h1);
        out_ready = 1'b1;
        for (int w = 0; w < 4; w++) begin
            chk($sformatf("ovf.drain%0d.valid", w), 32'(out_valid), 32'h1);
            chk($sformatf("ovf.drain%0d.data", w), out_data, word_of(4 * w + 1));
            tick();
        end
        chk("ovf.drained_empty", 32'(out_valid), 32'h0);
        chk("ovf.still_set", 32'(overflow), 32'h1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("ovf.cleared", 32'(overflow), 32'h0);

        // full FIFO: the 20th pixel commits in the same cycle as a pop
        out_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (k == 19) out_ready = 1'b1;
            pixel(8'(8'h40 + k));
            out_ready = 1'b0;
        end
        chk("fullpop.no_ovf", 32'(overflow), 32'h0);
        out_ready = 1'b1;
        for (int w = 1; w < 5; w++) begin
            chk($sformatf("fullpop.word%0d.valid", w), 32'(out_valid), 32'h1);
            chk($sformatf("fullpop.word%0d.data", w), out_data, word_of(8'h40 + 4 * w));
            tick();
        end
        chk("fullpop.empty", 32'(out_valid), 32'h0);

        // asynchronous reset mid-word with one word buffered
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) pixel(8'(8'h11 + k));
        chk("rst.pre_valid", 32'(out_valid), 32'h1);
        #2 rst = 1'b0;
        #1;
        chk_out("rst.async", 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) pixel(8'(8'h21 + k));
        chk_out("rst.after", 1'b1, 32'h2423_2221, 4'hF, 1'b0, 1'b0);
        out_ready = 1'b1;
        tick();
        chk("rst.after_pop", 32'(out_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gray_pixel_packer.md
# gray_pixel_packer

Receive-side companion of the RGB-to-gray converter. Consumes the converter's `output_valid`/`GRAY` result stream and rounds each 32-bit fixed-point gray value to an 8-bit pixel, saturating at 255. Packs four pixels per 32-bit word and buffers the words in a small FIFO. Presents the words downstream on a valid/ready handshake, with partial-word flush at line/frame end and a sticky overflow flag.

## Interface
- `FRAC_BITS`, 8: number of fractional bits in `in_gray`; legal range 1..24.
- `DEPTH`, 4: output word FIFO depth; power of two, at least 2.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  pixel strobe; driven by converter `output_valid`; one pixel per high cycle.
- `in_gray`  in  32  unsigned fixed-point gray value; driven by converter `GRAY`.
- `flush`  in  1  single-cycle pulse; closes the current partial word.
- `out_valid`  out  1  FIFO head word available.
- `out_ready`  in  1  downstream accepts head word.
- `out_data`  out  32  packed pixels; byte k = k-th pixel of the word (little-endian).
- `out_keep`  out  4  byte enables for `out_data`.
- `out_last`  out  1  word was closed by `flush`.
- `overflow`  out  1  sticky; a word was dropped because the FIFO was full.
- `clr_overflow`  in  1  synchronous clear of `overflow`.

## Operation
- Pixel conversion, combinational:
  - `sum = in_gray + 2^(FRAC_BITS-1)`, computed at 33 bits.
  - `pix = sum >> FRAC_BITS`.
  - If `pix > 255`, then `pix = 255`.
- Packing: byte index counter `idx` (2 bits, reset 0) and a 32-bit assembly register.
  - On `in_valid`, `pix` is written to byte `idx` and `idx` increments.
  - When `idx` wraps 3→0, the word is committed with `keep=4'b1111`, `last=0`.
- Flush, when `idx != 0`:
  - Commit the partial word. Unfilled bytes are 0, `keep` has ones for filled bytes only, `last=1`.
  - `idx` returns to 0.
- Flush when `idx == 0` and no simultaneous `in_valid`: no effect.
- Simultaneous `in_valid` and `flush`: the pixel is placed first, then the word is committed with `last=1`.
  - If that pixel is the 4th, the word is committed once, with `keep=1111` and `last=1`.
- Commit target is the FIFO, which holds `{data, keep, last}`.
  - Commit while the FIFO is full and no pop in the same cycle: the word is dropped, `overflow` is set, and `idx` still resets to 0.
  - Commit while full with a pop in the same cycle: accepted, no drop.
- Output side:
  - `out_valid` = FIFO not empty.
  - `out_data`/`out_keep`/`out_last` show the head entry.
  - A pop occurs when `out_valid && out_ready`.
  - Outputs stay stable while `out_valid && !out_ready`.
- Overflow flag:
  - `clr_overflow` clears `overflow`.
  - A set and a clear in the same cycle leave `overflow` = 1 (set wins).
- No backpressure toward the converter; it has no ready input. Words lost to overflow are the only loss mechanism.

## Timing
- Reset (`rst` low, asynchronous):
  - `out_valid`=0, `out_data`=0, `out_keep`=0, `out_last`=0, `overflow`=0.
  - `idx`=0, FIFO empty.
- Reset mid-word discards the partial word; reset with words in the FIFO discards them.
- Input acceptance is one pixel per cycle, sustained.
- Commit latency: a word completed or flushed in cycle N shows `out_valid`=1 in cycle N+1 when the FIFO was empty.
- FIFO occupancy: push and pop in the same cycle leave occupancy unchanged. Full = `DEPTH` entries, empty = 0. Pointers wrap modulo `DEPTH`.
- Throughput: one word per cycle out when `out_ready` is held high.

## Test plan
- Rounding/saturation, `FRAC_BITS`=8:
  - Pixels 0x0000_4C80, 0x0000_4C7F, 0x0001_2000, 0x0000_0000 → one word `out_data`=0x00FF_4C4D, `out_keep`=1111, `out_last`=0, `out_valid` high one cycle after the 4th pixel.
- Partial flush:
  - Pixels 0x1000 and 0x2000, then `flush` → `out_data`=0x0000_2010, `out_keep`=0011, `out_last`=1.
  - A `flush` with `idx`=0 afterwards produces no word.
- Simultaneous `in_valid` + `flush` on the 4th pixel (0x0100, 0x0200, 0x0300, 0x0400) → single word 0x0403_0201, `keep`=1111, `last`=1.
- Backpressure/overflow, `DEPTH`=4, `out_ready`=0, 20 consecutive pixels → words 1-4 buffered, word 5 dropped, `overflow`=1.
  - Release `out_ready` → exactly 4 words out in order.
  - Pulse `clr_overflow` → `overflow`=0.
- Full FIFO with same-cycle pop and commit → no drop, `overflow` stays 0, occupancy stays 4.
- Assert `rst` low after 2 pixels with 1 word buffered → all outputs 0 immediately.
  - After release, 4 new pixels → the next word contains only the new pixels.
